// File: rtl/change_dispenser_if.sv
// Payout request, coin-ejector handshake and inventory access bundle.
// Ejector handshake is four-phase: eject one-hot rises, ejector raises eject_ack,
// eject falls, ejector drops eject_ack; only then may the next coin be requested.
interface change_dispenser_if #(
    parameter int AW = 16,
    parameter int CW = 8
) ();
    logic          start;
    logic [AW-1:0] amount;
    logic          eject_ack;
    logic          load_inv;
    logic [1:0]    inv_sel;
    logic [CW-1:0] inv_val;
    logic          busy;
    logic [3:0]    eject;
    logic          done;
    logic [AW-1:0] shortfall;
    logic [CW-1:0] inv_rd;
    logic [3:0]    empty;
    logic [2:0]    dbg_state;

    modport master (
        output start, amount, eject_ack, load_inv, inv_sel, inv_val,
        input  busy, eject, done, shortfall, inv_rd, empty, dbg_state
    );

    modport slave (
        input  start, amount, eject_ack, load_inv, inv_sel, inv_val,
        output busy, eject, done, shortfall, inv_rd, empty, dbg_state
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout engine: highest denomination first, limited by per-coin
// inventory, one coin per four-phase ejector handshake, unpaid rest as shortfall.
module change_dispenser #(
    parameter int AW = 16,
    parameter int CW = 8,
    parameter int D0 = 50,
    parameter int D1 = 20,
    parameter int D2 = 10,
    parameter int D3 = 5
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_EJECT   = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [AW-1:0] DEN [4] = '{AW'(D0), AW'(D1), AW'(D2), AW'(D3)};

    state_t        state_q, state_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [AW-1:0] shortfall_q, shortfall_d;
    logic [1:0]    cur_q, cur_d;
    logic [3:0]    eject_q, eject_d;
    logic [CW-1:0] inv_q [4];
    logic [CW-1:0] inv_d [4];

    logic          sel_found;
    logic [1:0]    sel_idx;

    // Scan from the smallest coin upward so the highest usable denomination wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rem_q >= DEN[i] && inv_q[i] != '0) begin
                sel_found = 1'b1;
                sel_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        shortfall_d = shortfall_q;
        cur_d       = cur_q;
        eject_d     = '0;
        inv_d       = inv_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load_inv) inv_d[bus.inv_sel] = bus.inv_val;
                if (bus.start) begin
                    rem_d       = bus.amount;
                    shortfall_d = '0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_found) begin
                    cur_d   = sel_idx;
                    eject_d = 4'b0001 << sel_idx;
                    state_d = S_EJECT;
                end else begin
                    shortfall_d = rem_q;
                    state_d     = S_DONE;
                end
            end
            S_EJECT: begin
                eject_d = eject_q;
                if (bus.eject_ack) begin
                    rem_d        = rem_q - DEN[cur_q];
                    inv_d[cur_q] = inv_q[cur_q] - CW'(1);
                    eject_d      = '0;
                    state_d      = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!bus.eject_ack) state_d = S_SELECT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            shortfall_q <= '0;
            cur_q       <= 2'd0;
            eject_q     <= '0;
            for (int i = 0; i < 4; i++) inv_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            shortfall_q <= shortfall_d;
            cur_q       <= cur_d;
            eject_q     <= eject_d;
            for (int i = 0; i < 4; i++) inv_q[i] <= inv_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) bus.empty[i] = (inv_q[i] == '0);
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.eject     = eject_q;
    assign bus.shortfall = shortfall_q;
    assign bus.inv_rd    = inv_q[bus.inv_sel];
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout sequences, handshake
// holding, ignored inputs while busy and asynchronous reset mid-payout.
module tb_change_dispenser;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [3:0] exp_q[$];

    change_dispenser_if #(.AW(16), .CW(8)) bus ();

    change_dispenser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic load(input logic [1:0] sel, input logic [7:0] val);
        bus.load_inv = 1'b1;
        bus.inv_sel  = sel;
        bus.inv_val  = val;
        @(negedge clk);
        bus.load_inv = 1'b0;
    endtask

    task automatic load_all(input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3);
        load(2'd0, v0);
        load(2'd1, v1);
        load(2'd2, v2);
        load(2'd3, v3);
    endtask

    task automatic check_inv(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        bus.inv_sel = sel;
        #1;
        check(tag, bus.inv_rd, exp);
    endtask

    // Runs one payout with an automatic ejector that acks ack_delay cycles after a request.
    task automatic run_payout(input logic [15:0] amt, input int ack_delay, input logic [15:0] exp_short);
        logic [3:0] prev;
        int         cnt;
        bit         finished;
        prev = '0;
        cnt = 0;
        finished = 0;
        bus.start  = 1'b1;
        bus.amount = amt;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            if (bus.eject != 0 && prev == 0) begin
                if (exp_q.size() == 0) check("eject_extra", bus.eject, 0);
                else check("eject_seq", bus.eject, exp_q.pop_front());
            end
            prev = bus.eject;
            if (bus.done) begin
                finished = 1;
                check("shortfall", bus.shortfall, exp_short);
            end else begin
                if (bus.eject != 0 && !bus.eject_ack) begin
                    if (cnt >= ack_delay) bus.eject_ack = 1'b1;
                    else cnt++;
                end else if (bus.eject == 0 && bus.eject_ack) begin
                    bus.eject_ack = 1'b0;
                    cnt = 0;
                end
                @(negedge clk);
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        check("eject_missing", exp_q.size(), 0);
        exp_q.delete();
        bus.eject_ack = 1'b0;
        @(negedge clk);
        check("done_single", bus.done, 0);
        check("busy_after_done", bus.busy, 0);
    endtask

    initial begin
        int hi_cnt;
        bit seen;
        n_checks = 0;
        n_fail = 0;
        bus.start = 0; bus.amount = '0; bus.eject_ack = 0;
        bus.load_inv = 0; bus.inv_sel = '0; bus.inv_val = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_eject", bus.eject, 0);
        check("rst_done", bus.done, 0);
        check("rst_shortfall", bus.shortfall, 0);
        check("rst_empty", bus.empty, 4'b1111);
        check_inv("rst_inv", 2'd1, 0);
        rst = 1'b1;
        @(negedge clk);

        // Full inventory, 85 sen: one of each coin.
        load_all(10, 10, 10, 10);
        check("load_empty", bus.empty, 4'b0000);
        check_inv("load_inv2", 2'd2, 10);
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        run_payout(16'd85, 1, 16'd0);
        for (int i = 0; i < 4; i++) check_inv("t1_inv", 2'(i), 9);

        // No 20s: 85 = 50 + 10*3 + 5.
        load_all(10, 0, 10, 10);
        exp_q = '{4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        run_payout(16'd85, 0, 16'd0);
        check_inv("t2_inv10", 2'd2, 7);
        check("t2_empty", bus.empty, 4'b0010);

        // Amount below smallest coin: done after the second edge, no eject.
        load_all(10, 10, 10, 10);
        bus.start = 1'b1; bus.amount = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check("t3_busy_sel", bus.busy, 1);
        check("t3_done_early", bus.done, 0);
        @(negedge clk);
        check("t3_done", bus.done, 1);
        check("t3_eject", bus.eject, 0);
        check("t3_shortfall", bus.shortfall, 3);
        @(negedge clk);
        check("t3_busy_end", bus.busy, 0);

        // Short inventory, 100 sen: 50+5+5 paid, 40 unpaid.
        load_all(1, 0, 0, 2);
        exp_q = '{4'b0001, 4'b1000, 4'b1000};
        run_payout(16'd100, 2, 16'd40);
        check("t4_empty", bus.empty, 4'b1111);

        // Held handshake, plus start/load while busy.
        load(2'd0, 5);
        bus.start = 1'b1; bus.amount = 16'd50;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("t5_eject_first", bus.eject, 4'b0001);
        hi_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 0); bus.amount = 16'd20;
            bus.load_inv = (i == 1); bus.inv_sel = 2'd0; bus.inv_val = 8'd99;
            @(negedge clk);
            if (bus.eject == 4'b0001) hi_cnt++;
        end
        bus.start = 0; bus.load_inv = 0;
        check("t5_eject_hold", hi_cnt, 5);
        check_inv("t5_inv_busy", 2'd0, 5);
        bus.eject_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_rel_eject", bus.eject, 0);
            check("t5_rel_state", bus.dbg_state, 3);
        end
        bus.eject_ack = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.eject != 0) check("t5_second_eject", bus.eject, 0);
            if (bus.done) seen = 1;
        end
        check("t5_done_seen", seen, 1);
        check("t5_shortfall", bus.shortfall, 0);
        @(negedge clk);
        check("t5_idle", bus.busy, 0);
        check_inv("t5_inv_after", 2'd0, 4);

        // Asynchronous reset while a coin request is up.
        load(2'd0, 10);
        bus.start = 1'b1; bus.amount = 16'd50;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("t6_eject_pre", bus.eject, 4'b0001);
        #2 rst = 1'b0;
        #1;
        check("t6_eject_rst", bus.eject, 0);
        check("t6_busy_rst", bus.busy, 0);
        check("t6_done_rst", bus.done, 0);
        bus.inv_sel = 2'd0;
        #1;
        check("t6_inv_rst", bus.inv_rd, 0);
        rst = 1'b1;
        @(negedge clk);
        load_all(0, 0, 3, 3);
        exp_q = '{4'b0100, 4'b1000};
        run_payout(16'd15, 1, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Coin payout engine for the vending machine. On a start strobe it pays out a sen amount (refund or change) using greedy highest-denomination-first selection, bounded by per-denomination coin inventory. It drives the coin ejector one coin at a time over a four-phase request/acknowledge handshake. Any amount it cannot pay is reported as a shortfall.

Parameters:
AW, 16, width of amount and shortfall in sen
CW, 8, width of each inventory counter
D0, 50, denomination index 0 in sen (highest)
D1, 20, denomination index 1 in sen
D2, 10, denomination index 2 in sen
D3, 5, denomination index 3 in sen (lowest); required ordering D0>D1>D2>D3>0

Ports:
clk  in  1  system clock; all flops update on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle payout request; sampled only in S_idle
amount  in  AW  sen to pay; latched when start is accepted
eject_ack  in  1  ejector acknowledge (four-phase)
load_inv  in  1  write inventory counter inv_sel with inv_val; accepted only in S_idle
inv_sel  in  2  inventory index for load and read
inv_val  in  CW  inventory load value
busy  out  1  high in every state except S_idle
eject  out  4  one-hot coin request; bit i = denomination Di
done  out  1  one-cycle pulse when payout ends
shortfall  out  AW  unpaid remainder of the last payout; held until next accepted start
inv_rd  out  CW  current count of inventory inv_sel (combinational read)
empty  out  4  bit i high when inventory i == 0

Behaviour:
- Reset (rst=0, asynchronous): state=S_idle; rem=0; all four inventories=0; eject=0, done=0, busy=0, shortfall=0; empty=4'b1111.
- States: S_idle, S_select, S_eject, S_release, S_done.
- S_idle: busy=0.
  - start=1 → rem<=amount, shortfall<=0, go S_select.
  - load_inv=1 → inventory[inv_sel]<=inv_val in the same cycle.
  - start and load_inv together: both take effect; S_select sees the new count.
- S_select (exactly 1 cycle):
  - Choose the lowest index i with Di<=rem and inventory[i]>0; latch cur=i and go S_eject.
  - If no index qualifies, go S_done. This includes rem==0.
- S_eject: eject[cur]=1, all other eject bits 0.
  - Held until eject_ack=1 at a rising edge. At that edge: rem<=rem-Dcur, inventory[cur]<=inventory[cur]-1, go S_release.
  - eject is registered and drops in the first S_release cycle.
- S_release: eject=0; stay until eject_ack=0, then go S_select.
- S_done: done=1 for this one cycle; shortfall<=rem on entry (valid while done is high); next state S_idle.
- Arithmetic:
  - rem never underflows, because a coin is chosen only if Di<=rem.
  - An inventory never underflows, because a coin is chosen only if its count is >0.
  - No carry or saturation is needed.
- Ignored inputs:
  - start while busy is ignored, with no queuing.
  - load_inv while busy is ignored; the inventory is unchanged.
- eject_ack already high when S_eject is entered: accepted at the first edge, giving a 1-cycle eject pulse.
- Latency:
  - start at edge k → S_select after edge k.
  - First eject is high after edge k+1.
  - A zero-coin payout has done high after edge k+1 and busy=0 after edge k+2.
- Reset mid-payout: immediate return to S_idle. eject and done drop asynchronously. Inventories are cleared and the remaining amount is discarded.

Test Plan:
- Inventories all 10, start amount=85, ack after 1 cycle, released next cycle → eject sequence 0001,0010,0100,1000 (50,20,10,5); shortfall=0; inventories 9,9,9,9; single done pulse; busy low the cycle after done.
- inv20=0, others 10, amount=85 → eject 50,10,10,10,5; shortfall=0; inv10=7; empty=4'b0010.
- amount=3, inventories full → no eject; done high after edge k+1; shortfall=3.
- inv50=1, inv20=0, inv10=0, inv5=2, amount=100 → eject 50,5,5; shortfall=40; empty=4'b1111.
- Handshake: eject_ack held low 5 cycles → eject bit stays high 5+ cycles, rem unchanged. eject_ack held high 3 cycles after accept → FSM stays in S_release, no second eject.
- Protocol edge cases:
  - start during an active payout is ignored.
  - load_inv while busy leaves inv_rd unchanged.
  - rst pulsed low while eject is high → eject=0 immediately, inv_rd=0, busy=0. A new start after reset completes normally after inventories are reloaded.
